// File: rtl/led_flow_ctrl.sv
// led_flow_ctrl: ping-pong running-light controller.
//
// Every edge (rising or falling) of tick_in is one time unit. After STEP_EDGES
// units the single lit bit moves one position, bouncing between bit 0 and the
// MSB. step_pulse marks each cycle in which led shows a new step position.
//
// Build option:
//   LED_FLOW_SYNC_EN  defined   : tick_in passes through a 2-flop synchronizer
//                                 (s1 -> s2), 2 clk from sample to led update.
//                     undefined : s2 samples tick_in directly (tick_in must come
//                                 from the clk domain), 1 clk from sample to
//                                 led update.
// Pattern, counting and FSM behaviour are the same in both builds.

module led_flow_ctrl #(
   parameter int LED_W      = 4,    // number of LEDs, >= 2
   parameter int STEP_EDGES = 500,  // tick_in edges per pattern step, >= 1
   parameter int CNT_W      = 10    // 2**CNT_W >= STEP_EDGES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick_in,
   input  logic             en,
   output logic [LED_W-1:0] led,
   output logic             step_pulse
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LEFT  = 2'd1,
      RIGHT = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_EDGES - 1);
   localparam logic [LED_W-1:0] LED_BIT0 = {{(LED_W-1){1'b0}}, 1'b1};

   logic             s2;          // last sampled tick_in level
   logic             d;           // s2 delayed by one clk
   logic             tick_edge;   // any tick_in transition seen this cycle

   state_t           state;
   state_t           state_nxt;
   logic [LED_W-1:0] led_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             step_nxt;
   logic             cnt_last;

`ifdef LED_FLOW_SYNC_EN
   logic s1;

   // Two-flop synchronizer for tick_in plus the edge-detect delay stage.
   always_ff @(posedge clk) begin
      // NOTE: sequential state always uses non-blocking assignments so every
      // flop samples the pre-edge value of its neighbours.
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         d  <= 1'b0;
      end else begin
         s1 <= tick_in;
         s2 <= s1;
         d  <= s2;
      end
   end
`else
   // Single sampling register for a clk-domain tick_in plus the delay stage.
   always_ff @(posedge clk) begin
      // NOTE: sequential state always uses non-blocking assignments so every
      // flop samples the pre-edge value of its neighbours.
      if (rst) begin
         s2 <= 1'b0;
         d  <= 1'b0;
      end else begin
         s2 <= tick_in;
         d  <= s2;
      end
   end
`endif

   // Both tick_in edges count as one time unit each.
   assign tick_edge = s2 ^ d;
   assign cnt_last  = (cnt == CNT_LAST);

   // Next-state, next-pattern and edge-counter logic.
   always_comb begin
      // NOTE: every output of this block gets a default first; a path that
      // skipped an assignment would otherwise infer a latch.
      state_nxt = state;
      led_nxt   = led;
      cnt_nxt   = cnt;
      step_nxt  = 1'b0;

      case (state)
         IDLE: begin
            // Edges arriving here are dropped; the count always restarts at 0.
            led_nxt = '0;
            cnt_nxt = '0;
            if (en) begin
               state_nxt = LEFT;
               led_nxt   = LED_BIT0;
            end
         end

         LEFT: begin
            if (!en) begin
               // Disable wins over a coincident step.
               state_nxt = IDLE;
               led_nxt   = '0;
               cnt_nxt   = '0;
            end else if (tick_edge) begin
               if (cnt_last) begin
                  cnt_nxt  = '0;
                  step_nxt = 1'b1;
                  if (led[LED_W-1]) begin
                     // MSB has had its one step; bounce back.
                     state_nxt = RIGHT;
                     led_nxt   = led >> 1;
                  end else begin
                     led_nxt = led << 1;
                  end
               end else begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
            end
         end

         RIGHT: begin
            if (!en) begin
               state_nxt = IDLE;
               led_nxt   = '0;
               cnt_nxt   = '0;
            end else if (tick_edge) begin
               if (cnt_last) begin
                  cnt_nxt  = '0;
                  step_nxt = 1'b1;
                  if (led[0]) begin
                     // Bit 0 has had its one step; bounce back.
                     state_nxt = LEFT;
                     led_nxt   = led << 1;
                  end else begin
                     led_nxt = led >> 1;
                  end
               end else begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
            end
         end

         default: begin
            state_nxt = IDLE;
            led_nxt   = '0;
            cnt_nxt   = '0;
         end
      endcase
   end

   // State, pattern, counter and strobe registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         led        <= '0;
         cnt        <= '0;
         step_pulse <= 1'b0;
      end else begin
         state      <= state_nxt;
         led        <= led_nxt;
         cnt        <= cnt_nxt;
         step_pulse <= step_nxt;
      end
   end

endmodule
